opcode_dispatch: RTL and testbench
==================================

# opcode_dispatch

Drain-side controller for the opcode FIFO (`fifobuff`). It pops one 3-bit opcode at a time from the FIFO and holds it in a register. It then issues the opcode to the floating-point execution unit over a valid/ready handshake and waits for completion before fetching the next one. It sits between `fifobuff.opcode_out` and the FP unit's command port, and provides single-outstanding-op sequencing, NOP filtering, completion counting and a completion timeout.

## Interface
- `TIMEOUT`, 16: max cycles spent in WAIT_DONE before the op is abandoned; legal range 2..65535.
- `CNT_W`, 8: width of `dispatch_count`.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  allows new fetches. Deassertion does not abort an op already fetched.
- `fifo_empty`  in  1  FIFO has no entries.
- `fifo_read`  out  1  one-cycle pop strobe to FIFO `read`.
- `opcode_in`  in  3  FIFO `opcode_out`; valid in the cycle after `fifo_read`.
- `issue_valid`  out  1  opcode presented to FP unit.
- `issue_op`  out  3  opcode to FP unit; stable while `issue_valid`=1.
- `issue_ready`  in  1  FP unit accepts when `issue_valid`&&`issue_ready`.
- `op_done`  in  1  FP unit completion pulse.
- `busy`  out  1  state != IDLE.
- `dispatch_count`  out  CNT_W  completed ops, wraps modulo 2^CNT_W.
- `timeout_err`  out  1  sticky; set on timeout, cleared only by `rst`.

## Operation
- States: IDLE, FETCH, CAPTURE, ISSUE, WAIT_DONE. All outputs are decoded from registered state and registers; no input-to-output combinational paths.
- IDLE: if `enable` && !`fifo_empty`, go to FETCH. Otherwise stay.
- FETCH: `fifo_read`=1 for exactly this cycle. Always go to CAPTURE; `fifo_empty` is not re-checked.
- CAPTURE: `op_reg` <= `opcode_in`. Then, using the sampled value:
  - if it equals OP_NOP (3'b000), return to IDLE with no issue and no count increment;
  - otherwise go to ISSUE.
- ISSUE: `issue_valid`=1, `issue_op`=`op_reg`. Hold for as long as needed. When `issue_ready`=1, go to WAIT_DONE and clear the timer to 0.
- WAIT_DONE: the timer increments each cycle.
  - `op_done`=1: `dispatch_count`++ and go to IDLE.
  - Otherwise, timer == TIMEOUT-1: `timeout_err` <= 1, no count, go to IDLE.
  - If both occur in the same cycle, done wins and no error is raised.
- `op_done` is ignored outside WAIT_DONE.
- `dispatch_count` wraps from 2^CNT_W-1 to 0 with no flag.
- Reset mid-operation: every register returns to its reset value next edge. A popped-but-unissued opcode is discarded. An outstanding FP op is forgotten, and a later `op_done` is ignored in IDLE.

## Timing
- Reset values: state=IDLE, `fifo_read`=0, `issue_valid`=0, `issue_op`=0, `busy`=0, `dispatch_count`=0, `timeout_err`=0, timer=0, `op_reg`=0.
- Cycle N: IDLE sees a non-empty FIFO.
- N+1: FETCH with `fifo_read`=1.
- N+2: CAPTURE samples `opcode_in`.
- N+3: first cycle of `issue_valid`.
- Minimum op occupancy is 5 cycles (IDLE→FETCH→CAPTURE→ISSUE→WAIT_DONE→IDLE) when `issue_ready` and `op_done` each arrive on their first possible cycle.
- A NOP occupies 3 cycles: FETCH, CAPTURE, IDLE.
- Back-to-back: the next FETCH can occur at the earliest 1 cycle after returning to IDLE.
- Timeout: WAIT_DONE lasts exactly TIMEOUT cycles when `op_done` never arrives.
- `fifo_read` is never asserted twice without an intervening IDLE, so at most one pop is in flight.

## Structure
- Shared package `fp_pkg` holds:
  - `opcode_t` (logic [2:0]);
  - constant `OP_NOP` = 3'b000;
  - `dispatch_state_t` enum (IDLE, FETCH, CAPTURE, ISSUE, WAIT_DONE).
- Sub-module `timeout_ctr`: parameter TIMEOUT; inputs `clk`, `rst`, `clear`, `run`; output `expired` (registered compare to TIMEOUT-1).
- All other logic lives in `opcode_dispatch`.

## Test plan
- Reset, then FIFO holding 3'b001, with `issue_ready`=1 and `op_done` one cycle after acceptance:
  - `fifo_read` pulses once at cycle 1 after leaving IDLE;
  - `issue_op`=3'b001 with `issue_valid` at cycle 3;
  - `dispatch_count`=1; `busy` drops to 0.
- FIFO holding 3'b000 then 3'b010:
  - no `issue_valid` for the NOP;
  - 3'b010 is issued;
  - `dispatch_count`=1.
- `issue_ready` held low for 6 cycles:
  - `issue_valid`=1 and `issue_op` stable for all 6 cycles;
  - acceptance on cycle 7;
  - timer starts only after acceptance.
- TIMEOUT=4, `op_done` never asserted:
  - `timeout_err`=1 after exactly 4 WAIT_DONE cycles;
  - return to IDLE; `dispatch_count` unchanged;
  - error remains set through a later successful op.
- `op_done` coincident with the timer expiry cycle:
  - `timeout_err` stays 0;
  - `dispatch_count` increments.
- `rst` asserted during ISSUE of 3'b110:
  - next cycle all outputs are at reset values;
  - stray `op_done` afterwards leaves `dispatch_count`=0.
- CNT_W=2, 5 ops:
  - `dispatch_count` sequence is 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared opcode and dispatch-state definitions for the FP command path.
package fp_pkg;

    typedef logic [2:0] opcode_t;

    localparam opcode_t OP_NOP = 3'b000;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        ISSUE,
        WAIT_DONE
    } dispatch_state_t;

endpackage

// File: rtl/timeout_ctr.sv
// Cycle counter for the completion wait; expired is high in the cycle the
// count sits at TIMEOUT-1, so the wait lasts exactly TIMEOUT cycles.
module timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] count;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            expired <= 1'b0;
        end else if (clear) begin
            count   <= '0;
            expired <= 1'b0;
        end else if (run) begin
            count   <= count + W'(1);
            expired <= ((count + W'(1)) == LAST);
        end
    end

endmodule

// File: rtl/opcode_dispatch.sv
// Drains one opcode at a time from the opcode FIFO and issues it to the FP
// unit, waiting for completion (or timeout) before fetching the next.
module opcode_dispatch
    import fp_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             fifo_empty,
    output logic             fifo_read,
    input  logic [2:0]       opcode_in,
    output logic             issue_valid,
    output logic [2:0]       issue_op,
    input  logic             issue_ready,
    input  logic             op_done,
    output logic             busy,
    output logic [CNT_W-1:0] dispatch_count,
    output logic             timeout_err
);

    dispatch_state_t state;
    dispatch_state_t state_next;
    opcode_t         op_reg;
    logic            expired;
    logic            timer_clear;
    logic            timer_run;

    assign timer_clear = (state == ISSUE) && issue_ready;
    assign timer_run   = (state == WAIT_DONE);

    timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .run     (timer_run),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: defaulting state_next first keeps this block free of inferred latches.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:      if (enable && !fifo_empty) state_next = FETCH;
            FETCH:     state_next = CAPTURE;
            CAPTURE:   state_next = (opcode_t'(opcode_in) == OP_NOP) ? IDLE : ISSUE;
            ISSUE:     if (issue_ready) state_next = WAIT_DONE;
            WAIT_DONE: if (op_done || expired) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Completion takes priority over a simultaneous timer expiry.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_reg         <= OP_NOP;
            dispatch_count <= '0;
            timeout_err    <= 1'b0;
        end else begin
            if (state == CAPTURE) begin
                op_reg <= opcode_in;
            end
            if (state == WAIT_DONE) begin
                if (op_done) begin
                    dispatch_count <= dispatch_count + CNT_W'(1);
                end else if (expired) begin
                    timeout_err <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        fifo_read   = (state == FETCH);
        issue_valid = (state == ISSUE);
        issue_op    = (state == ISSUE) ? op_reg : OP_NOP;
        busy        = (state != IDLE);
    end

endmodule

// File: tb/tb_opcode_dispatch.sv
// Bench for opcode_dispatch: FIFO model, auto-responding FP unit, vector
// table, directed corner sequences and a randomized run against a model.
module tb_opcode_dispatch;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 2;

    logic             clk;
    logic             rst;
    logic             enable;
    logic             fifo_empty;
    logic             fifo_read;
    logic [2:0]       opcode_in;
    logic             issue_valid;
    logic [2:0]       issue_op;
    logic             issue_ready;
    logic             op_done;
    logic             busy;
    logic [CNT_W-1:0] dispatch_count;
    logic             timeout_err;

    logic auto_done;
    logic force_done;
    assign op_done = auto_done | force_done;

    int total = 0;
    int bad   = 0;

    int ready_dly = 0;
    int done_dly  = 1;

    logic [2:0] fifo_arr [0:255];
    logic [7:0] wr_ptr = '0;
    logic [7:0] rd_ptr = '0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    logic [2:0] issued_arr [0:255];
    logic [7:0] issued_n  = '0;
    logic [7:0] issued_rd = '0;

    typedef struct {
        logic [2:0] op;
        int         r;
        int         d;
        int         busy;
        int         first_valid;
        int         count;
        bit         err;
    } vec_t;

    vec_t vq [$];

    opcode_dispatch #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .fifo_empty     (fifo_empty),
        .fifo_read      (fifo_read),
        .opcode_in      (opcode_in),
        .issue_valid    (issue_valid),
        .issue_op       (issue_op),
        .issue_ready    (issue_ready),
        .op_done        (op_done),
        .busy           (busy),
        .dispatch_count (dispatch_count),
        .timeout_err    (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: registered output, valid the cycle after the pop strobe.
    always @(posedge clk) begin
        if (fifo_read && (wr_ptr != rd_ptr)) begin
            opcode_in <= fifo_arr[rd_ptr];
            rd_ptr    <= rd_ptr + 8'd1;
        end
    end

    // FP unit model: accepts after ready_dly ISSUE cycles, pulses done on the
    // done_dly-th cycle after acceptance (0 = never), logs accepted opcodes.
    initial begin
        int vcnt;
        int wcnt;
        bit in_wait;
        bit done_prev;
        bit hs;
        bit rst_e;
        issue_ready = 1'b0;
        auto_done   = 1'b0;
        vcnt = 0; wcnt = 0; in_wait = 0; done_prev = 0;
        forever begin
            @(posedge clk);
            hs    = issue_valid && issue_ready;
            rst_e = rst;
            if (hs && !rst_e) begin
                issued_arr[issued_n] = issue_op;
                issued_n = issued_n + 8'd1;
            end
            #1;
            auto_done = 1'b0;
            if (rst_e) begin
                in_wait = 0; done_prev = 0; vcnt = 0;
                issue_ready = 1'b0;
            end else begin
                if (in_wait && (done_prev || wcnt >= TIMEOUT)) in_wait = 0;
                if (hs) begin
                    in_wait = 1;
                    wcnt = 0;
                end
                done_prev = 0;
                if (in_wait) begin
                    wcnt++;
                    auto_done = (wcnt == done_dly);
                    done_prev = auto_done;
                end
                if (issue_valid) begin
                    issue_ready = (vcnt >= ready_dly);
                    vcnt++;
                end else begin
                    issue_ready = 1'b0;
                    vcnt = 0;
                end
            end
        end
    end

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_issue(input string name, input bit exp_issued,
                               input logic [2:0] exp_op);
        check({name, ".accepts"}, issued_n - issued_rd, exp_issued ? 1 : 0);
        if (exp_issued && (issued_n != issued_rd))
            check({name, ".op"}, issued_arr[issued_rd], exp_op);
        issued_rd = issued_n;
    endtask

    task automatic push(input logic [2:0] op);
        fifo_arr[wr_ptr] = op;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic add_vec(input logic [2:0] op, input int r, input int d,
                           input int bl, input int fv, input int cnt, input bit err);
        vec_t v;
        v.op = op; v.r = r; v.d = d; v.busy = bl;
        v.first_valid = fv; v.count = cnt; v.err = err;
        vq.push_back(v);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge busy drops.
    task automatic run_op(input logic [2:0] op, input int r, input int d,
                          output int busy_len, output int reads,
                          output int first_valid, output bit stable);
        int guard;
        ready_dly = r;
        done_dly  = d;
        push(op);
        busy_len = 0; reads = 0; first_valid = -1; stable = 1'b1; guard = 0;
        @(negedge clk);
        while (!busy && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        while (busy && guard < 200) begin
            if (fifo_read) reads++;
            if (issue_valid) begin
                if (first_valid < 0) first_valid = busy_len;
                if (issue_op !== op) stable = 1'b0;
            end
            busy_len++;
            guard++;
            @(negedge clk);
        end
    endtask

    initial begin
        int         exp_count;
        bit         exp_err;
        int         bl, rd, fv, g, first_rd, second_rd, vcyc;
        bit         st;
        logic [2:0] op;
        int         r, d;
        bit         completes;

        rst = 1'b1; enable = 1'b0; force_done = 1'b0;
        repeat (2) @(negedge clk);
        check("reset.fifo_read", fifo_read, 0);
        check("reset.issue_valid", issue_valid, 0);
        check("reset.issue_op", issue_op, 0);
        check("reset.busy", busy, 0);
        check("reset.count", dispatch_count, 0);
        check("reset.err", timeout_err, 0);
        rst = 1'b0;
        enable = 1'b1;

        //        op     r  d  busy fv cnt err
        add_vec(3'd1, 0, 1, 4,  2, 1, 0);
        add_vec(3'd0, 0, 1, 2, -1, 1, 0);
        add_vec(3'd2, 0, 1, 4,  2, 2, 0);
        add_vec(3'd3, 6, 2, 11, 2, 3, 0);
        add_vec(3'd4, 0, 4, 7,  2, 0, 0);
        add_vec(3'd5, 1, 0, 8,  2, 0, 1);
        add_vec(3'd7, 0, 3, 6,  2, 1, 1);
        add_vec(3'd0, 0, 1, 2, -1, 1, 1);
        add_vec(3'd6, 2, 2, 7,  2, 2, 1);
        add_vec(3'd1, 6, 0, 13, 2, 2, 1);

        foreach (vq[i]) begin
            run_op(vq[i].op, vq[i].r, vq[i].d, bl, rd, fv, st);
            check($sformatf("vec%0d.busy_len", i), bl, vq[i].busy);
            check($sformatf("vec%0d.reads", i), rd, 1);
            check($sformatf("vec%0d.first_valid", i), fv, vq[i].first_valid);
            check($sformatf("vec%0d.op_stable", i), st, 1);
            check_issue($sformatf("vec%0d", i), vq[i].first_valid >= 0, vq[i].op);
            check($sformatf("vec%0d.count", i), dispatch_count, vq[i].count);
            check($sformatf("vec%0d.err", i), timeout_err, vq[i].err);
        end
        exp_count = 2;
        exp_err   = 1'b1;

        // NOP followed immediately by a real op, both queued up front.
        ready_dly = 0; done_dly = 1;
        push(3'd0);
        push(3'd2);
        first_rd = -1; second_rd = -1; rd = 0; bl = 0; vcyc = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (busy) bl++;
            if (issue_valid) vcyc++;
            if (fifo_read) begin
                rd++;
                if (first_rd < 0) first_rd = c;
                else second_rd = c;
            end
        end
        exp_count = (exp_count + 1) % (1 << CNT_W);
        check("b2b.reads", rd, 2);
        check("b2b.read_gap", second_rd - first_rd, 3);
        check("b2b.busy_cycles", bl, 6);
        check("b2b.valid_cycles", vcyc, 1);
        check_issue("b2b", 1'b1, 3'd2);
        check("b2b.count", dispatch_count, exp_count);

        // enable low blocks fetches; dropping it mid-op does not abort.
        enable = 1'b0; ready_dly = 0; done_dly = 2;
        push(3'd3);
        bl = 0; rd = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy) bl++;
            if (fifo_read) rd++;
        end
        check("en_off.busy", bl, 0);
        check("en_off.reads", rd, 0);
        enable = 1'b1;
        g = 0;
        @(negedge clk);
        while (!busy && g < 10) begin
            @(negedge clk);
            g++;
        end
        enable = 1'b0;
        bl = 0;
        while (busy && g < 60) begin
            bl++;
            g++;
            @(negedge clk);
        end
        enable = 1'b1;
        exp_count = (exp_count + 1) % (1 << CNT_W);
        check("en_drop.busy_len", bl, 5);
        check_issue("en_drop", 1'b1, 3'd3);
        check("en_drop.count", dispatch_count, exp_count);

        // Randomized ops against the occupancy/count/error rules.
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(7, 0));
            r  = int'($urandom_range(3, 0));
            d  = int'($urandom_range(5, 0));
            completes = (op != 3'd0) && (d >= 1) && (d <= TIMEOUT);
            run_op(op, r, d, bl, rd, fv, st);
            if (completes) exp_count = (exp_count + 1) % (1 << CNT_W);
            if (op != 3'd0 && !completes) exp_err = 1'b1;
            check($sformatf("rnd%0d.busy_len", i), bl,
                  (op == 3'd0) ? 2 : 3 + r + (completes ? d : TIMEOUT));
            check($sformatf("rnd%0d.reads", i), rd, 1);
            check($sformatf("rnd%0d.op_stable", i), st, 1);
            check_issue($sformatf("rnd%0d", i), op != 3'd0, op);
            check($sformatf("rnd%0d.count", i), dispatch_count, exp_count);
            check($sformatf("rnd%0d.err", i), timeout_err, exp_err);
        end

        // Reset while 3'b110 waits in ISSUE, then a stray completion pulse.
        ready_dly = 100; done_dly = 1;
        push(3'b110);
        g = 0;
        @(negedge clk);
        while (!issue_valid && g < 10) begin
            @(negedge clk);
            g++;
        end
        check("rstmid.in_issue", issue_valid, 1);
        check("rstmid.op", issue_op, 3'b110);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid.fifo_read", fifo_read, 0);
        check("rstmid.issue_valid", issue_valid, 0);
        check("rstmid.issue_op", issue_op, 0);
        check("rstmid.busy", busy, 0);
        check("rstmid.count", dispatch_count, 0);
        check("rstmid.err", timeout_err, 0);
        force_done = 1'b1;
        repeat (2) @(negedge clk);
        force_done = 1'b0;
        @(negedge clk);
        check("stray_done.count", dispatch_count, 0);
        check("stray_done.busy", busy, 0);
        check_issue("stray_done", 1'b0, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
